// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative unsigned MUL/DIV/MOD unit for the execute stage.
// One shift-add or restoring-division step per clock. stall_req holds the
// pipeline from the accepting cycle through the DONE cycle.
// Optional macro MULDIV_EARLY_EXIT_EN: MUL finishes once the remaining
// multiplier bits are zero, and divide-by-zero finishes after one iteration.
module muldiv_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cy,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [3:0] {
    OP_MUL = 4'b1000,
    OP_DIV = 4'b1001,
    OP_MOD = 4'b1010
  } op_e;

  state_e state, state_nxt;
  op_e    op_q;

  // acc: MUL partial product, or DIV {remainder, remaining dividend/quotient}.
  // mcand: MUL shifted multiplicand; for DIV the low half keeps the dividend.
  // opb: MUL multiplier (shifted right), or DIV divisor (held).
  logic [2*WIDTH-1:0] acc, acc_nxt, mcand, prod_nxt, quot_nxt;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   div_q, div_r;
  logic [WIDTH:0]     rem_sh, diff;
  logic [CW-1:0]      cnt;
  logic               op_ok, accept, is_mul, dz, ge, last_iter;

  assign op_ok  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign is_mul = (op_q == OP_MUL);
  assign dz     = !is_mul && (opb == '0);

`ifdef MULDIV_EARLY_EXIT_EN
  assign last_iter = (cnt == CW'(1)) || dz || (is_mul && (opb[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt == CW'(1));
`endif

  // Next value of the datapath for one iteration of the latched operation.
  always_comb begin
    prod_nxt = acc + (opb[0] ? mcand : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = rem_sh - {1'b0, opb};
    // remainder stays below the divisor, so the borrow bit is a valid compare
    ge       = ~diff[WIDTH];
    quot_nxt = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    acc_nxt  = is_mul ? prod_nxt : quot_nxt;
    div_q    = dz ? '1 : quot_nxt[WIDTH-1:0];
    div_r    = dz ? mcand[WIDTH-1:0] : quot_nxt[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start && op_ok) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    stall_req = busy | accept;
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= op_e'(4'b0000);
      opb       <= '0;
      acc       <= '0;
      mcand     <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      cy        <= 1'b0;
    end else if (accept) begin
      op_q  <= op_e'(op);
      opb   <= b;
      cnt   <= CW'(WIDTH);
      mcand <= {{WIDTH{1'b0}}, a};
      acc   <= (op == OP_MUL) ? '0 : {{WIDTH{1'b0}}, a};
    end else if (state == RUN) begin
      cnt <= last_iter ? '0 : cnt - CW'(1);
      acc <= acc_nxt;
      if (is_mul) begin
        mcand <= mcand << 1;
        opb   <= opb >> 1;
      end
      if (last_iter) begin
        if (is_mul) begin
          result    <= prod_nxt[WIDTH-1:0];
          result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
          cy        <= |prod_nxt[2*WIDTH-1:WIDTH];
        end else if (op_q == OP_DIV) begin
          result    <= div_q;
          result_hi <= div_r;
          cy        <= dz;
        end else begin
          result    <= div_r;
          result_hi <= div_q;
          cy        <= dz;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: directed and random checks of muldiv_seq_unit against
// an arithmetic reference model (products, / and % operators).
module tb_muldiv_seq_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         cy, busy, done, stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] last_r = '0, last_h = '0;
  logic         last_c = 1'b0;

  muldiv_seq_unit #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .cy(cy),
    .busy(busy), .done(done), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h, output logic c);
    logic [2*W-1:0] p;
    logic [W-1:0]   q, m;
    if (o == 4'b1000) begin
      p = (2*W)'(x) * (2*W)'(y);
      r = p[W-1:0];
      h = p[2*W-1:W];
      c = (h != 0);
    end else begin
      q = (y == 0) ? '1 : x / y;
      m = (y == 0) ? x : x % y;
      r = (o == 4'b1001) ? q : m;
      h = (o == 4'b1001) ? m : q;
      c = (y == 0);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] o, input logic [W-1:0] y);
    int k;
`ifdef MULDIV_EARLY_EXIT_EN
    if (o == 4'b1000) begin
      k = 1;
      while ((y >> k) != 0) k++;
      return k;
    end
    if (y == 0) return 1;
`endif
    k = W;
    return k;
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit poke);
    logic [W-1:0] er, eh;
    logic         ec;
    int           n, lat;
    model(o, x, y, er, eh, ec);
    lat = exp_lat(o, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 check("stall_accept", stall_req, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
    n = 0;
    while (!done && n < 4*W) begin
      check("busy_run", busy, 1);
      check("stall_run", stall_req, 1);
      if (poke && n == 3) begin
        start = 1'b1; op = 4'b1000; a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check("done_seen", done, 1);
    check("latency", n, lat);
    check("result", result, er);
    check("result_hi", result_hi, eh);
    check("cy", cy, ec);
    check("busy_done", busy, 1);
    check("stall_done", stall_req, 1);
    last_r = er; last_h = eh; last_c = ec;
    @(posedge clk);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("busy_after", busy, 0);
    check("stall_after", stall_req, 0);
    check("result_hold", result, er);
  endtask

  initial begin
    logic [3:0] ro;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_cy", cy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall_req, 0);
    rst = 1'b0;

    do_op(4'b1000, 8'd13, 8'd11, 1'b0);
    do_op(4'b1000, 8'd200, 8'd3, 1'b0);
    do_op(4'b1001, 8'd100, 8'd7, 1'b0);
    do_op(4'b1010, 8'd100, 8'd7, 1'b0);
    do_op(4'b1001, 8'd55, 8'd0, 1'b0);
    do_op(4'b1010, 8'd55, 8'd0, 1'b0);
    do_op(4'b1000, 8'd1, 8'd2, 1'b0);
    do_op(4'b1000, 8'd255, 8'd255, 1'b0);
    do_op(4'b1000, 8'd77, 8'd0, 1'b0);
    do_op(4'b1001, 8'd5, 8'd9, 1'b0);
    do_op(4'b1000, 8'd13, 8'd11, 1'b1);

    // invalid opcode is ignored
    @(negedge clk);
    start = 1'b1; op = 4'b0011; a = 8'h5A; b = 8'h3C;
    #1 check("stall_invalid", stall_req, 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_invalid", busy, 0);
    check("done_invalid", done, 0);
    check("result_invalid", result, last_r);
    check("result_hi_invalid", result_hi, last_h);
    check("cy_invalid", cy, last_c);

    // reset at edge 4 of a MUL aborts it
    @(negedge clk);
    start = 1'b1; op = 4'b1000; a = 8'd200; b = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_result_hi", result_hi, 0);
    check("abort_cy", cy, 0);
    repeat (W + 2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    do_op(4'b1000, 8'd6, 8'd7, 1'b0);

    // random operations
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       ro = 4'b1000;
        1:       ro = 4'b1001;
        default: ro = 4'b1010;
      endcase
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 7));
        default: rb = W'($urandom);
      endcase
      do_op(ro, ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Iterative multi-cycle MUL/DIV/MOD execution unit for the CPU's ALU opcodes 4'b1000 (MUL), 4'b1001 (DIV) and 4'b1010 (MOD).
- Sits beside the single-cycle ALU in the execute stage.
- Raises stall_req for the whole operation. The pipeline hazard/stall controller holds its enables low until completion, instead of relying on a fixed hold count.

Parameters:
WIDTH, 8, operand/result width in bits; iteration count per operation.
CW, 4, width of the internal iteration counter; must satisfy 2^CW > WIDTH.

Ports:
clk  input  1  single system clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin an operation; sampled on posedge.
op  input  4  ALU opcode: 4'b1000 MUL, 4'b1001 DIV, 4'b1010 MOD.
a  input  WIDTH  multiplicand / dividend.
b  input  WIDTH  multiplier / divisor.
result  output  WIDTH  MUL low half; DIV quotient; MOD remainder.
result_hi  output  WIDTH  MUL high half; DIV remainder; MOD quotient.
cy  output  1  MUL: high half nonzero; DIV/MOD: divide by zero.
busy  output  1  operation in progress (RUN or DONE state).
done  output  1  one-cycle completion pulse; results valid.
stall_req  output  1  stall request to the hazard controller.

Behaviour:
- Reset: clk and one synchronous active-high reset rst; rst sampled high on posedge forces state IDLE.
  - Reset values: result=0, result_hi=0, cy=0, busy=0, done=0, counter=0, internal operand/accumulator registers=0.
  - Reset mid-operation aborts it: no done pulse, results cleared.
- States:
  - IDLE -> RUN on posedge with start=1 and op valid. a, b and op are latched; counter=WIDTH.
  - RUN: one iteration per posedge, counter decrements. At the edge where counter reaches 0: final results are registered, cy is computed, state -> DONE.
  - DONE: lasts exactly one cycle, then -> IDLE unconditionally.
- Latency: with the accepting edge as edge 0, done=1 and results valid in the cycle after edge WIDTH. busy=1 from after edge 0 through the done cycle. Back-to-back: a new start is accepted no earlier than the edge ending DONE.
- Invalid op (anything other than 1000/1001/1010) with start=1: ignored, stays IDLE, outputs unchanged.
- start while RUN/DONE: ignored; latched operands are unaffected by later changes of a, b or op.
- MUL: unsigned shift-add, 2*WIDTH-bit product. result = product low half, result_hi = product high half, cy = (high half != 0).
- DIV/MOD: unsigned restoring division, one quotient bit per iteration.
- Divide by zero (b==0): full latency still taken. Quotient = all ones, remainder = a, cy=1, mapped to result/result_hi per op.
- result/result_hi/cy hold their values until the next completion or reset.
- stall_req = (state != IDLE) | (state==IDLE & start & op valid). Combinational, so the pipeline freezes in the same cycle the unit accepts. It is low in the cycle after DONE.

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined:
  - MUL goes to DONE as soon as the remaining unshifted multiplier bits are all zero (minimum 1 iteration).
  - Divide by zero goes to DONE after exactly 1 iteration.
  - Result values are identical to the full-latency case; only the done timing changes.
- Undefined: every operation takes exactly WIDTH iterations, giving a fixed latency.

Test Plan (WIDTH=8):
- MUL a=13, b=11 -> done in cycle after edge 8; result=0x8F, result_hi=0x00, cy=0; stall_req high from accepting cycle through done cycle.
- MUL a=200, b=3 -> result=0x58, result_hi=0x02, cy=1. DIV a=100, b=7 -> result=14, result_hi=2, cy=0. MOD same operands -> result=2, result_hi=14.
- DIV a=55, b=0 -> result=0xFF, result_hi=0x37, cy=1, done after edge 8 (edge 1 with MULDIV_EARLY_EXIT_EN).
- start with op=4'b0011 -> busy, stall_req, done stay 0; outputs unchanged. start pulsed again mid-RUN with new a/b -> ignored, first results correct.
- rst asserted at edge 4 of a MUL -> next cycle busy=0, done=0, result=0; a following MUL 6*7 completes with result=42.
- MUL a=1, b=2 with MULDIV_EARLY_EXIT_EN -> done after edge 2, result=2; without the macro, done after edge 8.
